// File: rtl/poly_voice_synth.sv
// poly_voice_synth
//   Polyphonic keypad synthesiser. A NUM_KEYS-wide keypad is synchronised
//   and scanned one key per clock. Pressed keys are allocated to NUM_VOICES
//   phase-accumulator oscillators. Each active voice produces a square, saw
//   or triangle sample. The voices are summed into a PWM duty value, which
//   drives a single PWM audio pin.
//
//   Optional build macro: VOICE_STEAL_EN. When it is defined, a newly pressed
//   key that finds every voice busy takes over the voice at a round-robin
//   steal pointer.
//
// Ports
//   clk           : system clock
//   n_rst         : synchronous active-low reset
//   keypad_i      : key levels, 1 = pressed (asynchronous to clk)
//   wave_sel      : 00 square, 01 saw, 10 triangle, 11 square
//   pwm           : registered PWM audio output
//   voices_active : registered count of allocated voices
module poly_voice_synth #(
  parameter int unsigned NUM_KEYS   = 14,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned ACC_BITS   = 16
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic [NUM_KEYS-1:0]                 keypad_i,
  input  logic [1:0]                          wave_sel,
  output logic                                pwm,
  output logic [$clog2(NUM_VOICES+1)-1:0]     voices_active
);

  localparam int unsigned KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned W  = PWM_BITS - $clog2(NUM_VOICES);
  localparam int unsigned AW = $clog2(NUM_VOICES + 1);
`ifdef VOICE_STEAL_EN
  localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
`endif

  // Phase increment for key k: one octave of semitones, doubled per octave.
  function automatic logic [ACC_BITS-1:0] inc_of(input int unsigned k);
    logic [31:0] base;
    case (k % 12)
      0:       base = 32'd439;
      1:       base = 32'd465;
      2:       base = 32'd493;
      3:       base = 32'd522;
      4:       base = 32'd553;
      5:       base = 32'd586;
      6:       base = 32'd621;
      7:       base = 32'd658;
      8:       base = 32'd697;
      9:       base = 32'd738;
      10:      base = 32'd782;
      default: base = 32'd829;
    endcase
    return ACC_BITS'(base << (k / 12));
  endfunction

  // One voice sample from the top W phase bits.
  function automatic logic [W-1:0] wave_of(input logic [1:0] sel,
                                           input logic [ACC_BITS-1:0] ph);
    logic [W-1:0] p;
    logic [W-1:0] t;
    p = ph[ACC_BITS-1 -: W];
    t = {p[W-2:0], 1'b0};
    case (sel)
      2'b01:   return p;
      2'b10:   return p[W-1] ? ~t : t;
      default: return p[W-1] ? '0 : '1;
    endcase
  endfunction

  logic [NUM_KEYS-1:0]   key_s1;
  logic [NUM_KEYS-1:0]   key_s2;
  logic [KW-1:0]         scan_ptr;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [PWM_BITS-1:0]   duty;
  logic [PWM_BITS-1:0]   mix;
  logic                  tick;

  logic [NUM_VOICES-1:0] v_valid;
  logic [KW-1:0]         v_key   [NUM_VOICES];
  logic [ACC_BITS-1:0]   v_phase [NUM_VOICES];
  logic [ACC_BITS-1:0]   v_inc   [NUM_VOICES];

  logic [NUM_VOICES-1:0] nxt_valid;
  logic [KW-1:0]         nxt_key   [NUM_VOICES];
  logic [ACC_BITS-1:0]   nxt_phase [NUM_VOICES];
  logic [ACC_BITS-1:0]   nxt_inc   [NUM_VOICES];

  logic                  pressed;
  logic [ACC_BITS-1:0]   cur_inc;
  logic [NUM_VOICES-1:0] own_mask;
  logic [NUM_VOICES-1:0] free_mask;
  logic                  free_found;
  logic [NUM_VOICES-1:0] grant;
  logic                  release_now;
  logic [AW-1:0]         valid_cnt;

`ifdef VOICE_STEAL_EN
  logic [VW-1:0]         steal_ptr;
  logic [VW-1:0]         nxt_steal_ptr;
  logic [NUM_KEYS-1:0]   robbed;
  logic [NUM_KEYS-1:0]   nxt_robbed;
  logic [NUM_VOICES-1:0] steal_mask;
  logic                  steal_now;
  logic                  scan_robbed;
  logic [KW-1:0]         victim;
`endif

  assign tick = (pwm_cnt == '1);

  // Key scan and voice allocation.
  always_comb begin
    pressed     = 1'b0;
    cur_inc     = '0;
    own_mask    = '0;
    free_mask   = '0;
    free_found  = 1'b0;
    grant       = '0;
    release_now = 1'b0;

    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (scan_ptr == KW'(k)) begin
        pressed = key_s2[k];
        cur_inc = inc_of(k);
      end
    end

    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      own_mask[i] = v_valid[i] && (v_key[i] == scan_ptr);
      if (!v_valid[i] && !free_found) begin
        free_mask[i] = 1'b1;
        free_found   = 1'b1;
      end
    end

`ifdef VOICE_STEAL_EN
    steal_now     = 1'b0;
    scan_robbed   = 1'b0;
    victim        = '0;
    nxt_steal_ptr = steal_ptr;
    nxt_robbed    = robbed;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      steal_mask[i] = (steal_ptr == VW'(i));
      if (steal_ptr == VW'(i))
        victim = v_key[i];
    end
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (scan_ptr == KW'(k))
        scan_robbed = robbed[k];
    end
`endif

    if (pressed && (own_mask == '0)) begin
      if (free_found) begin
        grant = free_mask;
      end
`ifdef VOICE_STEAL_EN
      // A key that lost its voice to a steal may only take a free voice,
      // otherwise two held keys would keep stealing from each other.
      else if (!scan_robbed) begin
        grant     = steal_mask;
        steal_now = 1'b1;
      end
`endif
    end
    release_now = !pressed && (own_mask != '0);

`ifdef VOICE_STEAL_EN
    if (steal_now)
      nxt_steal_ptr = (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + VW'(1);
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (steal_now && (victim == KW'(k)))
        nxt_robbed[k] = 1'b1;
      if ((scan_ptr == KW'(k)) && (!pressed || (grant != '0)))
        nxt_robbed[k] = 1'b0;
    end
`endif

    // Allocation changes override the phase advance on a coincident tick.
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      nxt_valid[i] = v_valid[i];
      nxt_key[i]   = v_key[i];
      nxt_inc[i]   = v_inc[i];
      nxt_phase[i] = (tick && v_valid[i]) ? v_phase[i] + v_inc[i] : v_phase[i];
      if (release_now && own_mask[i]) begin
        nxt_valid[i] = 1'b0;
        nxt_phase[i] = v_phase[i];
      end
      if (grant[i]) begin
        nxt_valid[i] = 1'b1;
        nxt_key[i]   = scan_ptr;
        nxt_phase[i] = '0;
        nxt_inc[i]   = cur_inc;
      end
    end
  end

  // Mixer: wave_sel is read only when the sum is latched on the tick.
  always_comb begin
    mix = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (v_valid[i])
        mix = mix + PWM_BITS'(wave_of(wave_sel, v_phase[i]));
    end
  end

  always_comb begin
    valid_cnt = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++)
      valid_cnt = valid_cnt + AW'(v_valid[i]);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      key_s1        <= '0;
      key_s2        <= '0;
      scan_ptr      <= '0;
      pwm_cnt       <= '0;
      duty          <= '0;
      pwm           <= 1'b0;
      voices_active <= '0;
      v_valid       <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        v_key[i]   <= '0;
        v_phase[i] <= '0;
        v_inc[i]   <= '0;
      end
`ifdef VOICE_STEAL_EN
      steal_ptr <= '0;
      robbed    <= '0;
`endif
    end else begin
      key_s1   <= keypad_i;
      key_s2   <= key_s1;
      scan_ptr <= (scan_ptr == KW'(NUM_KEYS - 1)) ? '0 : scan_ptr + KW'(1);
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      if (tick)
        duty <= mix;
      pwm           <= (pwm_cnt < duty);
      voices_active <= valid_cnt;
      v_valid       <= nxt_valid;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        v_key[i]   <= nxt_key[i];
        v_phase[i] <= nxt_phase[i];
        v_inc[i]   <= nxt_inc[i];
      end
`ifdef VOICE_STEAL_EN
      steal_ptr <= nxt_steal_ptr;
      robbed    <= nxt_robbed;
`endif
    end
  end

endmodule
